// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared types and constants for the instruction fetch unit
package instruction_fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_W          = 32;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  // Word index presented to the instruction memory for a byte PC.
  function automatic logic [31:0] word_index(input logic [31:0] pc);
    return {2'b00, pc[31:2]};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// rtl/instruction_fetch_unit_fetch_queue.sv - circular FIFO of fetched {pc, instr} entries
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         valid,
  output logic         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  fetch_entry_t     slots [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a full queue can still accept a push.
  assign do_pop  = pop && valid && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  assign valid = (count != '0);
  assign full  = (count == CNT_FULL);
  assign head  = slots[head_ptr];

  // Entry storage; cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (do_push) begin
      slots[tail_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= tail_ptr + PTR_ONE;
      if (do_pop)  head_ptr <= head_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, fetch FSM and redirect handling; IFETCH_ALIGN_CHECK_EN faults misaligned redirects
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          IMEM_WORDS  = 128
) (
  input  logic               Clk,
  input  logic               Rst_n,
  output logic [31:0]        IMemAddress,
  input  logic [INSTR_W-1:0] IMemInstruction,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [INSTR_W-1:0] Instruction,
  output logic [31:0]        InstrPC,
  input  logic               Redirect,
  input  logic [31:0]        RedirectPC,
  output logic               FetchFault
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  pc;
  logic [31:0]  pc_next;
  logic         in_range;
  logic         misaligned;
  logic         deq;
  logic         enq;
  logic         q_valid;
  logic         q_full;
  fetch_entry_t q_head;
  fetch_entry_t push_data;

  assign IMemAddress = word_index(pc);
  assign in_range    = (word_index(pc) < IMEM_LIMIT);
  assign deq         = q_valid && InstrReady;
  assign push_data   = '{pc: pc, instr: IMemInstruction};

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misaligned = (RedirectPC[1:0] != 2'b00);
`else
  logic unused_redirect_low;
  assign misaligned          = 1'b0;
  assign unused_redirect_low = ^RedirectPC[1:0];
`endif

  // State and PC registers; reset restarts fetching at RESET_PC.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Next PC/state and enqueue decision; a redirect overrides fetching and faults.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    enq        = 1'b0;
    if (Redirect) begin
      pc_next    = {RedirectPC[31:2], 2'b00};
      state_next = misaligned ? FAULT : RUN;
    end else if (state == RUN) begin
      if (!in_range) begin
        state_next = FAULT;
      end else if (!q_full || deq) begin
        enq     = 1'b1;
        pc_next = pc + 32'd4;
      end
    end
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_fetch_queue (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .flush    (Redirect),
    .push     (enq),
    .push_data(push_data),
    .pop      (deq),
    .head     (q_head),
    .valid    (q_valid),
    .full     (q_full)
  );

  assign InstrValid  = q_valid;
  assign Instruction = q_head.instr;
  assign InstrPC     = q_head.pc;
  assign FetchFault  = (state == FAULT);

endmodule
